// File: rtl/ans_pkg.sv
// Shared constants, command encodings and FSM state type for the ANS mode controller.
package ans_pkg;

   localparam int SYM_WIDTH   = 4;
   localparam int SYM_COUNT   = 16;
   localparam int STATE_WIDTH = 3;

   typedef logic [1:0] cmd_t;

   localparam cmd_t CMD_IDLE = 2'b00;
   localparam cmd_t CMD_ENC  = 2'b01;
   localparam cmd_t CMD_DEC  = 2'b10;
   localparam cmd_t CMD_LOAD = 2'b11;

   typedef enum logic [STATE_WIDTH-1:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_ENC   = 3'd2,
      ST_FLUSH = 3'd3,
      ST_DEC   = 3'd4,
      ST_DRAIN = 3'd5
   } state_t;

endpackage

// File: rtl/ans_ctrl_if.sv
// Pin-side command and data handshake bundle of the ANS core.
interface ans_ctrl_if #(
   parameter int SYM_WIDTH = ans_pkg::SYM_WIDTH
) ();
   import ans_pkg::*;

   cmd_t                 cmd;
   logic                 in_vld;
   logic                 in_rdy;
   logic                 out_vld;
   logic                 out_rdy;
   logic [SYM_WIDTH-1:0] out;

   modport slave (
      input  cmd, in_vld, out_rdy,
      output in_rdy, out_vld, out
   );

   modport master (
      output cmd, in_vld, out_rdy,
      input  in_rdy, out_vld, out
   );
endinterface

// File: rtl/ans_ctrl_wdog.sv
// FLUSH/DRAIN watchdog: counts while run is high, clears otherwise; fire at all-ones.
// Only present when ANS_CTRL_WDOG_EN is defined.
`ifdef ANS_CTRL_WDOG_EN
module ans_ctrl_wdog #(
   parameter int WIDTH = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic fire
);
   logic [WIDTH-1:0] cnt_q;

   assign fire = &cnt_q;

   always_ff @(posedge clk) begin
      if (rst || !run) begin
         cnt_q <= '0;
      end else if (!fire) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end
endmodule
`endif

// File: rtl/ans_ctrl.sv
// ANS core mode controller: registers cmd and enables one engine at a time with safe teardown.
// Optional FLUSH/DRAIN watchdog is built when ANS_CTRL_WDOG_EN is defined.
module ans_ctrl #(
   parameter int SYM_WIDTH = ans_pkg::SYM_WIDTH,
   parameter int SYM_COUNT = ans_pkg::SYM_COUNT,
   parameter int WDOG_W    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   ans_ctrl_if.slave            bus,
   output logic                 ld_en,
   output logic                 enc_en,
   output logic                 dec_en,
   input  logic                 ld_in_rdy,
   input  logic                 enc_in_rdy,
   input  logic                 dec_in_rdy,
   input  logic                 enc_out_vld,
   input  logic                 dec_out_vld,
   input  logic [SYM_WIDTH-1:0] enc_out,
   input  logic [SYM_WIDTH-1:0] dec_out,
   input  logic                 dec_busy,
   output logic                 enc_flush,
   input  logic                 enc_flush_done,
   output logic                 table_vld,
   output logic                 err
);
   import ans_pkg::*;

   // state    | meaning
   // ST_IDLE  | no engine enabled, waiting for a command
   // ST_LOAD  | table loader enabled, counting nibbles
   // ST_ENC   | encoder enabled
   // ST_FLUSH | encoder emitting final state, input blocked
   // ST_DEC   | decoder enabled
   // ST_DRAIN | decoder finishing internal work, input blocked

   localparam int               CNT_W    = $clog2(SYM_COUNT) + 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SYM_COUNT - 1);

   state_t               state_q, state_d;
   cmd_t                 cmd_q;
   logic [CNT_W-1:0]     ld_cnt_q, ld_cnt_d;
   logic                 table_vld_q, table_vld_d;
   logic                 err_q, err_d;
   logic                 flush_q, flush_d;
   logic                 hs;
   logic                 wdog_fire;
   logic                 in_rdy_c, out_vld_c;
   logic [SYM_WIDTH-1:0] out_data_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cmd_q       <= CMD_IDLE;
         ld_cnt_q    <= '0;
         table_vld_q <= 1'b0;
         err_q       <= 1'b0;
         flush_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= bus.cmd;
         ld_cnt_q    <= ld_cnt_d;
         table_vld_q <= table_vld_d;
         err_q       <= err_d;
         flush_q     <= flush_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      ld_cnt_d    = ld_cnt_q;
      table_vld_d = table_vld_q;
      err_d       = err_q;
      flush_d     = 1'b0;
      hs          = 1'b0;
      ld_en       = 1'b0;
      enc_en      = 1'b0;
      dec_en      = 1'b0;
      in_rdy_c    = 1'b0;
      out_vld_c   = 1'b0;
      out_data_c  = '0;
      case (state_q)
         ST_IDLE: begin
            case (cmd_q)
               CMD_LOAD: begin
                  state_d     = ST_LOAD;
                  table_vld_d = 1'b0;
                  err_d       = 1'b0;
                  ld_cnt_d    = '0;
               end
               CMD_ENC: if (table_vld_q) state_d = ST_ENC; else err_d = 1'b1;
               CMD_DEC: if (table_vld_q) state_d = ST_DEC; else err_d = 1'b1;
               default: ;
            endcase
         end
         ST_LOAD: begin
            ld_en    = 1'b1;
            in_rdy_c = ld_in_rdy;
            hs       = bus.in_vld & ld_in_rdy;
            // A final nibble accepted on the pins completes the table even if cmd_q just dropped.
            if (hs && (ld_cnt_q == LAST_IDX)) begin
               table_vld_d = 1'b1;
               state_d     = ST_IDLE;
            end else if (cmd_q != CMD_LOAD) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else if (hs) begin
               ld_cnt_d = ld_cnt_q + 1'b1;
            end
         end
         ST_ENC: begin
            enc_en     = 1'b1;
            in_rdy_c   = enc_in_rdy;
            out_vld_c  = enc_out_vld;
            out_data_c = enc_out;
            if (cmd_q != CMD_ENC) begin
               state_d = ST_FLUSH;
               flush_d = 1'b1;
            end
         end
         ST_FLUSH: begin
            enc_en     = 1'b1;
            out_vld_c  = enc_out_vld;
            out_data_c = enc_out;
            if (enc_flush_done) begin
               state_d = ST_IDLE;
            end else if (wdog_fire) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end
         end
         ST_DEC: begin
            dec_en     = 1'b1;
            in_rdy_c   = dec_in_rdy;
            out_vld_c  = dec_out_vld;
            out_data_c = dec_out;
            if (cmd_q != CMD_DEC) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            dec_en     = 1'b1;
            out_vld_c  = dec_out_vld;
            out_data_c = dec_out;
            if (!dec_busy && !dec_out_vld) begin
               state_d = ST_IDLE;
            end else if (wdog_fire) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.in_rdy  = in_rdy_c;
   assign bus.out_vld = out_vld_c;
   assign bus.out     = out_vld_c ? out_data_c : '0;
   assign enc_flush   = flush_q;
   assign table_vld   = table_vld_q;
   assign err         = err_q;

`ifdef ANS_CTRL_WDOG_EN
   logic wdog_run;
   logic unused_sig;

   assign wdog_run   = (state_q == ST_FLUSH) || (state_q == ST_DRAIN);
   assign unused_sig = bus.out_rdy;

   ans_ctrl_wdog #(.WIDTH(WDOG_W)) u_wdog (
      .clk  (clk),
      .rst  (rst),
      .run  (wdog_run),
      .fire (wdog_fire)
   );
`else
   logic unused_sig;

   assign wdog_fire  = 1'b0;
   assign unused_sig = bus.out_rdy ^ (^WDOG_W);
`endif

endmodule

// File: tb/tb_ans_ctrl.sv
// Self-checking bench for ans_ctrl: reset, table load/abort, command gating, engine switching, drain.
module tb_ans_ctrl;
   import ans_pkg::*;

   localparam int TSW = 4;
   localparam int TSC = 16;

   typedef struct packed {
      logic           enc_en;
      logic           dec_en;
      logic           flush;
      logic           in_rdy;
      logic           out_vld;
      logic [TSW-1:0] data;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst;
   logic           ld_en, enc_en, dec_en;
   logic           ld_in_rdy, enc_in_rdy, dec_in_rdy;
   logic           enc_out_vld, dec_out_vld;
   logic [TSW-1:0] enc_out, dec_out;
   logic           dec_busy, enc_flush, enc_flush_done, table_vld, err;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sb[$];

   ans_ctrl_if #(.SYM_WIDTH(TSW)) bus ();

   ans_ctrl #(.SYM_WIDTH(TSW), .SYM_COUNT(TSC), .WDOG_W(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus),
      .ld_en          (ld_en),
      .enc_en         (enc_en),
      .dec_en         (dec_en),
      .ld_in_rdy      (ld_in_rdy),
      .enc_in_rdy     (enc_in_rdy),
      .dec_in_rdy     (dec_in_rdy),
      .enc_out_vld    (enc_out_vld),
      .dec_out_vld    (dec_out_vld),
      .enc_out        (enc_out),
      .dec_out        (dec_out),
      .dec_busy       (dec_busy),
      .enc_flush      (enc_flush),
      .enc_flush_done (enc_flush_done),
      .table_vld      (table_vld),
      .err            (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      int hs = 0;
      int guard = 0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      n_cmp++;
      if ({ld_en, enc_en, dec_en, table_vld, err, enc_flush, bus.in_rdy, bus.out_vld} !== 8'h00
          || bus.out !== 4'h0) begin
         n_bad++;
         $display("FAIL reset_init: got %b out=%h, want 00000000 out=0",
                  {ld_en, enc_en, dec_en, table_vld, err, enc_flush, bus.in_rdy, bus.out_vld}, bus.out);
      end
      bus.cmd    = CMD_LOAD;
      ld_in_rdy  = 1'b1;
      bus.in_vld = 1'b1;
      while (hs < 5 && guard < 50) begin
         if (bus.in_rdy === 1'b1) hs++;
         tick();
         guard++;
      end
      n_cmp++;
      if (hs != 5) begin
         n_bad++;
         $display("FAIL reset_partial_load: got %0d handshakes, want 5", hs);
      end
      bus.in_vld = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      bus.cmd = CMD_IDLE;
      n_cmp++;
      if ({table_vld, ld_en, enc_en, dec_en, err} !== 5'b0) begin
         n_bad++;
         $display("FAIL reset_mid_load: tv/ld/enc/dec/err=%b, want 00000",
                  {table_vld, ld_en, enc_en, dec_en, err});
      end
   endtask

   task automatic test_enc_no_table();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.cmd = CMD_ENC;
      tick();
      n_cmp++;
      if (err !== 1'b0 || enc_en !== 1'b0) begin
         n_bad++;
         $display("FAIL noenc_early: err=%b enc_en=%b, want 0 0", err, enc_en);
      end
      tick();
      n_cmp++;
      if (err !== 1'b1 || enc_en !== 1'b0) begin
         n_bad++;
         $display("FAIL noenc_err: err=%b enc_en=%b, want 1 0", err, enc_en);
      end
      tick();
      tick();
      n_cmp++;
      if (enc_en !== 1'b0) begin
         n_bad++;
         $display("FAIL noenc_hold: enc_en=%b, want 0", enc_en);
      end
      bus.cmd = CMD_IDLE;
      tick();
      tick();
   endtask

   task automatic test_load();
      int hs = 0;
      int guard = 0;
      bus.cmd    = CMD_LOAD;
      ld_in_rdy  = 1'b1;
      bus.in_vld = 1'b1;
      while (hs < TSC && guard < 100) begin
         if (bus.in_rdy === 1'b1) begin
            hs++;
            if (hs == TSC) bus.cmd = CMD_IDLE;
            if (hs == 8) begin
               n_cmp++;
               if (table_vld !== 1'b0 || ld_en !== 1'b1) begin
                  n_bad++;
                  $display("FAIL load_mid: table_vld=%b ld_en=%b, want 0 1", table_vld, ld_en);
               end
            end
         end
         tick();
         guard++;
      end
      bus.in_vld = 1'b0;
      n_cmp++;
      if (hs != TSC) begin
         n_bad++;
         $display("FAIL load_timeout: got %0d handshakes, want %0d", hs, TSC);
      end
      n_cmp++;
      if (table_vld !== 1'b1 || ld_en !== 1'b0) begin
         n_bad++;
         $display("FAIL load_done: table_vld=%b ld_en=%b, want 1 0", table_vld, ld_en);
      end
      tick();
      tick();
      n_cmp++;
      if (table_vld !== 1'b1 || ld_en !== 1'b0 || err !== 1'b0) begin
         n_bad++;
         $display("FAIL load_settled: table_vld=%b ld_en=%b err=%b, want 1 0 0", table_vld, ld_en, err);
      end
   endtask

   task automatic test_abort();
      int hs = 0;
      int guard = 0;
      bus.cmd    = CMD_LOAD;
      ld_in_rdy  = 1'b1;
      bus.in_vld = 1'b1;
      while (hs < 7 && guard < 50) begin
         if (bus.in_rdy === 1'b1) hs++;
         tick();
         guard++;
      end
      bus.in_vld = 1'b0;
      bus.cmd    = CMD_IDLE;
      n_cmp++;
      if (hs != 7) begin
         n_bad++;
         $display("FAIL abort_partial: got %0d handshakes, want 7", hs);
      end
      tick();
      tick();
      tick();
      n_cmp++;
      if ({ld_en, table_vld, err} !== 3'b001) begin
         n_bad++;
         $display("FAIL abort_result: ld_en/table_vld/err=%b, want 001", {ld_en, table_vld, err});
      end
   endtask

   task automatic test_enc_dec_switch();
      int             guard = 0;
      logic           v;
      logic [TSW-1:0] d;
      exp_t           e;
      bus.cmd        = CMD_ENC;
      enc_in_rdy     = 1'b1;
      dec_in_rdy     = 1'b1;
      enc_flush_done = 1'b0;
      while (enc_en !== 1'b1 && guard < 20) begin
         tick();
         guard++;
      end
      n_cmp++;
      if (enc_en !== 1'b1) begin
         n_bad++;
         $display("FAIL enc_enter: enc_en=%b after %0d cycles, want 1", enc_en, guard);
      end
      for (int i = 0; i < 6; i++) begin
         v           = 1'($urandom_range(0, 1));
         d           = TSW'($urandom);
         enc_out_vld = v;
         enc_out     = d;
         dec_out_vld = 1'b1;
         dec_out     = ~d;
         sb.push_back('{enc_en: 1'b1, dec_en: 1'b0, flush: 1'b0, in_rdy: 1'b1, out_vld: v,
                        data: (v ? d : 4'h0)});
         #1;
         e = sb.pop_front();
         n_cmp++;
         if ({enc_en, dec_en, enc_flush, bus.in_rdy, bus.out_vld, bus.out} !== e) begin
            n_bad++;
            $display("FAIL enc_stream[%0d]: got %b, want %b", i,
                     {enc_en, dec_en, enc_flush, bus.in_rdy, bus.out_vld, bus.out}, e);
         end
         tick();
      end
      enc_out_vld = 1'b1;
      enc_out     = 4'hA;
      dec_out_vld = 1'b0;
      dec_out     = 4'h5;
      bus.cmd     = CMD_DEC;
      sb.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'hA});
      sb.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'hA});
      sb.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'hA});
      sb.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
      sb.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0});
      for (int i = 0; i < 5; i++) begin
         tick();
         e = sb.pop_front();
         n_cmp++;
         if ({enc_en, dec_en, enc_flush, bus.in_rdy, bus.out_vld, bus.out} !== e) begin
            n_bad++;
            $display("FAIL switch_cycle[%0d]: got %b, want %b", i,
                     {enc_en, dec_en, enc_flush, bus.in_rdy, bus.out_vld, bus.out}, e);
         end
         if (i == 2) enc_flush_done = 1'b1;
         if (i == 3) begin
            enc_flush_done = 1'b0;
            enc_out_vld    = 1'b0;
         end
      end
      for (int i = 0; i < 4; i++) begin
         v           = 1'($urandom_range(0, 1));
         d           = TSW'($urandom);
         dec_out_vld = v;
         dec_out     = d;
         enc_out_vld = 1'b1;
         enc_out     = ~d;
         sb.push_back('{enc_en: 1'b0, dec_en: 1'b1, flush: 1'b0, in_rdy: 1'b1, out_vld: v,
                        data: (v ? d : 4'h0)});
         #1;
         e = sb.pop_front();
         n_cmp++;
         if ({enc_en, dec_en, enc_flush, bus.in_rdy, bus.out_vld, bus.out} !== e) begin
            n_bad++;
            $display("FAIL dec_stream[%0d]: got %b, want %b", i,
                     {enc_en, dec_en, enc_flush, bus.in_rdy, bus.out_vld, bus.out}, e);
         end
         tick();
      end
      enc_out_vld = 1'b0;
   endtask

   task automatic test_drain();
      int cycles = 0;
      int stuck = 0;
      dec_busy    = 1'b1;
      dec_out_vld = 1'b0;
      bus.cmd     = CMD_IDLE;
      tick();
      tick();
      n_cmp++;
      if (dec_en !== 1'b1 || bus.in_rdy !== 1'b0) begin
         n_bad++;
         $display("FAIL drain_enter: dec_en=%b in_rdy=%b, want 1 0", dec_en, bus.in_rdy);
      end
`ifdef ANS_CTRL_WDOG_EN
      while (dec_en === 1'b1 && cycles < 400) begin
         tick();
         cycles++;
      end
      n_cmp++;
      if (dec_en !== 1'b0 || err !== 1'b1 || cycles < 250 || cycles > 260) begin
         n_bad++;
         $display("FAIL wdog_fire: dec_en=%b err=%b after %0d cycles, want 0 1 near 256",
                  dec_en, err, cycles);
      end
      dec_busy = 1'b0;
`else
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (dec_en !== 1'b1) stuck++;
         cycles++;
      end
      n_cmp++;
      if (stuck != 0) begin
         n_bad++;
         $display("FAIL drain_hold: dec_en low in %0d of %0d cycles, want 0", stuck, cycles);
      end
      dec_busy = 1'b0;
      tick();
      tick();
      n_cmp++;
      if (dec_en !== 1'b0 || err !== 1'b0) begin
         n_bad++;
         $display("FAIL drain_exit: dec_en=%b err=%b, want 0 0", dec_en, err);
      end
`endif
   endtask

   initial begin
      rst            = 1'b1;
      bus.cmd        = CMD_IDLE;
      bus.in_vld     = 1'b0;
      bus.out_rdy    = 1'b1;
      ld_in_rdy      = 1'b0;
      enc_in_rdy     = 1'b0;
      dec_in_rdy     = 1'b0;
      enc_out_vld    = 1'b0;
      dec_out_vld    = 1'b0;
      enc_out        = '0;
      dec_out        = '0;
      dec_busy       = 1'b0;
      enc_flush_done = 1'b0;
      tick();
      test_reset();
      test_enc_no_table();
      test_load();
      test_abort();
      test_load();
      test_enc_dec_switch();
      test_drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
